// File: rtl/bist_6_3_counter_tester_if.sv
// Signal bundle between the 6:3 counter BIST engine and its wrapper/CUT side.
// With BIST_MISR_EN defined the bundle also carries the 8-bit MISR signature.
interface bist_6_3_counter_tester_if;
  logic       start;
  logic [5:0] tpg_x;
  logic [2:0] cut_o;
  logic       busy;
  logic       done;
  logic       pass;
  logic [6:0] err_cnt;
  logic [5:0] first_fail;
`ifdef BIST_MISR_EN
  logic [7:0] signature;

  modport master (
    output start, cut_o,
    input  tpg_x, busy, done, pass, err_cnt, first_fail, signature
  );
  modport slave (
    input  start, cut_o,
    output tpg_x, busy, done, pass, err_cnt, first_fail, signature
  );
`else
  modport master (
    output start, cut_o,
    input  tpg_x, busy, done, pass, err_cnt, first_fail
  );
  modport slave (
    input  start, cut_o,
    output tpg_x, busy, done, pass, err_cnt, first_fail
  );
`endif
endinterface

// File: rtl/bist_6_3_counter_tester.sv
// Exhaustive BIST engine for a 6:3 popcount counter with CUT_LAT-cycle output latency.
// Optional MISR signature output when BIST_MISR_EN is defined.
module bist_6_3_counter_tester #(
  parameter int unsigned CUT_LAT = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  bist_6_3_counter_tester_if.slave     bus
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

  localparam logic [2:0] DrainLast = 3'((CUT_LAT > 0) ? CUT_LAT - 1 : 0);

  state_e     state_q, state_d;
  logic [5:0] tpg_q, tpg_d;
  logic [2:0] drain_q, drain_d;
  logic [6:0] err_q, err_d;
  logic [5:0] ff_q, ff_d;
  logic       fail_q, fail_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;

  logic       start_go;
  logic       cmp_vld;
  logic [5:0] cmp_vec;
  logic       mismatch;

  function automatic logic [2:0] popcnt6(input logic [5:0] v);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 6; i++) begin
      cnt = cnt + {2'b00, v[i]};
    end
    return cnt;
  endfunction

  // The vector index travels with a valid bit so the compare lines up with the CUT latency.
  if (CUT_LAT == 0) begin : g_no_pipe
    assign cmp_vld = (state_q == StRun);
    assign cmp_vec = tpg_q;
  end else begin : g_pipe
    localparam int unsigned PipeDepth = CUT_LAT;
    logic [5:0]           vec_pipe_q [PipeDepth];
    logic [PipeDepth-1:0] vld_pipe_q;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        vld_pipe_q <= '0;
        for (int i = 0; i < PipeDepth; i++) begin
          vec_pipe_q[i] <= 6'd0;
        end
      end else begin
        vld_pipe_q[0] <= (state_q == StRun);
        vec_pipe_q[0] <= tpg_q;
        for (int i = 1; i < PipeDepth; i++) begin
          vld_pipe_q[i] <= vld_pipe_q[i-1];
          vec_pipe_q[i] <= vec_pipe_q[i-1];
        end
      end
    end

    assign cmp_vld = vld_pipe_q[PipeDepth-1];
    assign cmp_vec = vec_pipe_q[PipeDepth-1];
  end

  assign start_go = bus.start && ((state_q == StIdle) || (state_q == StDone));
  assign mismatch = cmp_vld && (bus.cut_o != popcnt6(cmp_vec));

  always_comb begin
    state_d = state_q;
    tpg_d   = tpg_q;
    drain_d = drain_q;
    err_d   = err_q;
    ff_d    = ff_q;
    fail_d  = fail_q;

    unique case (state_q)
      StIdle, StDone: begin
        if (start_go) begin
          state_d = StRun;
          tpg_d   = 6'd0;
          err_d   = 7'd0;
          ff_d    = 6'd0;
          fail_d  = 1'b0;
        end
      end
      StRun: begin
        if (tpg_q == 6'd63) begin
          state_d = (CUT_LAT > 0) ? StDrain : StDone;
          drain_d = 3'd0;
        end else begin
          tpg_d = tpg_q + 6'd1;
        end
      end
      StDrain: begin
        if (drain_q == DrainLast) begin
          state_d = StDone;
        end else begin
          drain_d = drain_q + 3'd1;
        end
      end
      default: state_d = StIdle;
    endcase

    // Compares only occur in RUN/DRAIN, so they never collide with the start clears.
    if (mismatch) begin
      err_d = err_q + 7'd1;
      if (!fail_q) begin
        ff_d   = cmp_vec;
        fail_d = 1'b1;
      end
    end

    // Status lags the state by one cycle so done rises on the edge after the last compare.
    busy_d = (state_q == StRun) || (state_q == StDrain);
    done_d = (state_q == StDone) && !start_go;
    pass_d = done_d && !fail_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      tpg_q   <= 6'd0;
      drain_q <= 3'd0;
      err_q   <= 7'd0;
      ff_q    <= 6'd0;
      fail_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      tpg_q   <= tpg_d;
      drain_q <= drain_d;
      err_q   <= err_d;
      ff_q    <= ff_d;
      fail_q  <= fail_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
    end
  end

  assign bus.tpg_x      = tpg_q;
  assign bus.busy       = busy_q;
  assign bus.done       = done_q;
  assign bus.pass       = pass_q;
  assign bus.err_cnt    = err_q;
  assign bus.first_fail = ff_q;

`ifdef BIST_MISR_EN
  logic [7:0] sig_q, sig_d;

  // Galois MISR for x^8+x^4+x^3+x^2+1; stops moving once compares end.
  always_comb begin
    sig_d = sig_q;
    if (start_go) begin
      sig_d = 8'hFF;
    end else if (cmp_vld) begin
      sig_d = {sig_q[6:0], 1'b0} ^ (sig_q[7] ? 8'h1D : 8'h00) ^ {5'b00000, bus.cut_o};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= 8'h00;
    end else begin
      sig_q <= sig_d;
    end
  end

  assign bus.signature = sig_q;
`endif

endmodule

// File: tb/tb_bist_6_3_counter_tester.sv
// Bench for the 6:3 counter BIST engine: a combinational-CUT instance and a 2-cycle CUT instance
// driven by fault-injectable CUT models and checked cycle-by-cycle against a run-level model.
module tb_bist_6_3_counter_tester;

  logic clk = 1'b0;
  logic rst;
  int   mode;

  always #5 clk = ~clk;

  bist_6_3_counter_tester_if if0 ();
  bist_6_3_counter_tester_if if1 ();

  bist_6_3_counter_tester #(.CUT_LAT(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0));
  bist_6_3_counter_tester #(.CUT_LAT(2)) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  // CUT model: 0 golden, 1 o[2] stuck-at-0, 2 o[0] stuck-at-1.
  function automatic logic [2:0] cut_fn(input logic [5:0] x, input int m);
    logic [2:0] p;
    p = 3'($countones(x));
    case (m)
      1:       return p & 3'b011;
      2:       return p | 3'b001;
      default: return p;
    endcase
  endfunction

  logic [2:0] r1, r2;
  assign if0.cut_o = cut_fn(if0.tpg_x, mode);
  always @(posedge clk) begin
    r1 <= cut_fn(if1.tpg_x, mode);
    r2 <= r1;
  end
  assign if1.cut_o = r2;

  int nvec  = 0;
  int nfail = 0;
  int cyc[2];
  bit trk[2];
  int exp_err[2];
  int exp_ff[2];
  int lat[2] = '{0, 2};

  task automatic chk(input string name, input int act, input int exp);
    nvec++;
    if (act != exp) begin
      nfail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Whole-run result: every vector whose faulty output differs from its popcount is an error.
  task automatic model_run(input int m, output int e, output int ff);
    e  = 0;
    ff = 0;
    for (int x = 0; x < 64; x++) begin
      if (cut_fn(6'(x), m) != 3'($countones(6'(x)))) begin
        if (e == 0) ff = x;
        e++;
      end
    end
  endtask

  task automatic check_cycle(input int d, input logic [5:0] t, input logic b, input logic dn,
                             input logic p, input logic [6:0] e, input logic [5:0] f);
    int c;
    int l;
    c = cyc[d];
    l = lat[d];
    chk($sformatf("dut%0d c%0d tpg_x", d, c), int'(t), (c > 63) ? 63 : c);
    chk($sformatf("dut%0d c%0d busy", d, c), int'(b), (c >= 1 && c <= 64 + l) ? 1 : 0);
    chk($sformatf("dut%0d c%0d done", d, c), int'(dn), (c >= 65 + l) ? 1 : 0);
    if (c >= 65 + l) begin
      chk($sformatf("dut%0d c%0d pass", d, c), int'(p), (exp_err[d] == 0) ? 1 : 0);
      chk($sformatf("dut%0d c%0d err_cnt", d, c), int'(e), exp_err[d]);
      chk($sformatf("dut%0d c%0d first_fail", d, c), int'(f), exp_ff[d]);
    end
    cyc[d] = c + 1;
    if (c >= 67 + l) trk[d] = 1'b0;
  endtask

  always @(negedge clk) begin
    if (trk[0]) check_cycle(0, if0.tpg_x, if0.busy, if0.done, if0.pass, if0.err_cnt,
                            if0.first_fail);
    if (trk[1]) check_cycle(1, if1.tpg_x, if1.busy, if1.done, if1.pass, if1.err_cnt,
                            if1.first_fail);
  end

  task automatic set_start(input int d, input logic v);
    if (d == 0) if0.start = v;
    else        if1.start = v;
  endtask

  task automatic run(input int d, input int m, input int repulse);
    mode = m;
    model_run(m, exp_err[d], exp_ff[d]);
    @(negedge clk);
    set_start(d, 1'b1);
    @(posedge clk);
    #1;
    set_start(d, 1'b0);
    cyc[d] = 0;
    trk[d] = 1'b1;
    if (repulse > 0) begin
      repeat (repulse) @(posedge clk);
      #1;
      set_start(d, 1'b1);
      @(posedge clk);
      #1;
      set_start(d, 1'b0);
    end
    for (int i = 0; i < 200 && trk[d]; i++) @(posedge clk);
    if (trk[d]) begin
      chk($sformatf("dut%0d run timeout", d), 1, 0);
      trk[d] = 1'b0;
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, " tpg_x"}, int'(if0.tpg_x), 0);
    chk({tag, " busy"}, int'(if0.busy), 0);
    chk({tag, " done"}, int'(if0.done), 0);
    chk({tag, " pass"}, int'(if0.pass), 0);
    chk({tag, " err_cnt"}, int'(if0.err_cnt), 0);
    chk({tag, " first_fail"}, int'(if0.first_fail), 0);
  endtask

  initial begin
    int e;
    int f;
    rst       = 1'b1;
    if0.start = 1'b0;
    if1.start = 1'b0;
    mode      = 0;
    trk[0]    = 1'b0;
    trk[1]    = 1'b0;
    #12;
    chk_zero("reset dut0");
    chk("reset dut1 done", int'(if1.done), 0);
    chk("reset dut1 busy", int'(if1.busy), 0);
    chk("reset dut1 err_cnt", int'(if1.err_cnt), 0);

    // Hand-computed pins on the model.
    model_run(1, e, f);
    chk("model sa0 err", e, 22);
    chk("model sa0 first", f, 15);
    model_run(2, e, f);
    chk("model sa1 err", e, 32);
    chk("model sa1 first", f, 0);
    @(negedge clk);
    rst = 1'b0;

    run(0, 0, 0);
    chk("golden pass", int'(if0.pass), 1);
    chk("golden err_cnt", int'(if0.err_cnt), 0);
    run(0, 1, 0);
    chk("o2sa0 err_cnt", int'(if0.err_cnt), 22);
    chk("o2sa0 first_fail", int'(if0.first_fail), 6'h0F);
    chk("o2sa0 pass", int'(if0.pass), 0);
    run(0, 2, 0);
    chk("o0sa1 err_cnt", int'(if0.err_cnt), 32);
    chk("o0sa1 first_fail", int'(if0.first_fail), 0);
    run(1, 0, 0);
    chk("lat2 golden pass", int'(if1.pass), 1);
    run(1, 1, 0);
    chk("lat2 o2sa0 err_cnt", int'(if1.err_cnt), 22);

    // Reset in the middle of a run.
    mode = 0;
    @(negedge clk);
    if0.start = 1'b1;
    @(posedge clk);
    #1;
    if0.start = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    chk("midrun tpg_x", int'(if0.tpg_x), 20);
    rst = 1'b1;
    #1;
    chk_zero("rst async");
    repeat (2) @(negedge clk);
    chk_zero("rst held");
    rst = 1'b0;
    run(0, 0, 0);
    chk("after rst pass", int'(if0.pass), 1);

    // start pulsed while busy must be ignored.
    run(0, 1, 30);
    chk("repulse err_cnt", int'(if0.err_cnt), 22);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
